// File: rtl/alu_rr_arbiter.sv
// Round-robin arbiter sharing one external ALU between two requesters; ALU_ARB_OPCHK_EN adds opcode checking.
// Latency: rsp_valid two edges after the grant edge (one edge for a rejected opcode when checking is enabled).
// Backpressure: one op in flight; ready is offered only while idle, and the response is held until rsp_ready.
module alu_rr_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [3:0]       req0_ctl,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [3:0]       req1_ctl,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic [3:0]       alu_ctl,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_zero,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_zero,
  output logic             rsp_err,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state;
  logic             last_grant;
  logic             gnt0;
  logic             gnt1;
  logic             take;
  logic [3:0]       sel_ctl;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;

  // On a tie the requester that was not granted last time wins.
  always_comb begin
    gnt0 = (state == IDLE) && req0_valid && (!req1_valid || last_grant);
    gnt1 = (state == IDLE) && req1_valid && (!req0_valid || !last_grant);
  end

  assign take       = gnt0 | gnt1;
  assign req0_ready = gnt0;
  assign req1_ready = gnt1;

  always_comb begin
    sel_ctl = req0_ctl;
    sel_a   = req0_a;
    sel_b   = req0_b;
    if (gnt1) begin
      sel_ctl = req1_ctl;
      sel_a   = req1_a;
      sel_b   = req1_b;
    end
  end

`ifdef ALU_ARB_OPCHK_EN
  logic sel_legal;
  logic err_q;

  always_comb begin
    sel_legal = 1'b0;
    case (sel_ctl)
      4'd0, 4'd1, 4'd2, 4'd6, 4'd7, 4'd12: sel_legal = 1'b1;
      default:                             sel_legal = 1'b0;
    endcase
  end

  assign rsp_err = err_q;
`else
  assign rsp_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      alu_ctl    <= 4'd0;
      alu_a      <= '0;
      alu_b      <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_data   <= '0;
      rsp_zero   <= 1'b0;
      busy       <= 1'b0;
`ifdef ALU_ARB_OPCHK_EN
      err_q      <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (take) begin
            last_grant <= gnt1;
            rsp_id     <= gnt1;
            busy       <= 1'b1;
`ifdef ALU_ARB_OPCHK_EN
            // A rejected opcode never reaches the ALU; it is answered directly.
            if (!sel_legal) begin
              rsp_data  <= '0;
              rsp_zero  <= 1'b0;
              err_q     <= 1'b1;
              rsp_valid <= 1'b1;
              state     <= RESP;
            end else begin
              alu_ctl <= sel_ctl;
              alu_a   <= sel_a;
              alu_b   <= sel_b;
              err_q   <= 1'b0;
              state   <= EXEC;
            end
`else
            alu_ctl <= sel_ctl;
            alu_a   <= sel_a;
            alu_b   <= sel_b;
            state   <= EXEC;
`endif
          end
        end
        EXEC: begin
          rsp_data  <= alu_out;
          rsp_zero  <= alu_zero;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Bench for alu_rr_arbiter: hosts a behavioural ALU, runs a vector table, directed corner sequences
// and a randomized phase scored against a transaction-level model (grant order, result, latency).
module tb_alu_rr_arbiter;
  localparam int W = 32;
`ifdef ALU_ARB_OPCHK_EN
  localparam bit OPCHK = 1'b1;
`else
  localparam bit OPCHK = 1'b0;
`endif

  logic         clk;
  logic         rst_n;
  logic         req0_valid, req0_ready, req1_valid, req1_ready;
  logic [3:0]   req0_ctl, req1_ctl, alu_ctl;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b, alu_a, alu_b, alu_out, rsp_data;
  logic         alu_zero, rsp_valid, rsp_ready, rsp_id, rsp_zero, rsp_err, busy;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  typedef struct {
    bit           id;
    logic [3:0]   ctl;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] d;
    bit           z;
    bit           e;
  } vec_t;

  typedef struct {
    bit           id;
    logic [W-1:0] d;
    bit           z;
    bit           e;
    int           cyc;
    int           lat;
  } exp_t;

  vec_t tbl[10];
  exp_t q[$];
  bit   m_last;
  bit   prev_valid;

  alu_rr_arbiter #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_ctl(req0_ctl), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_ctl(req1_ctl), .req1_a(req1_a), .req1_b(req1_b),
    .alu_ctl(alu_ctl), .alu_a(alu_a), .alu_b(alu_b), .alu_out(alu_out), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .rsp_zero(rsp_zero), .rsp_err(rsp_err), .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Stand-in for the shared MIPS-style ALU.
  always_comb begin
    alu_out = '0;
    case (alu_ctl)
      4'd0:    alu_out = alu_a & alu_b;
      4'd1:    alu_out = alu_a | alu_b;
      4'd2:    alu_out = alu_a + alu_b;
      4'd6:    alu_out = alu_a - alu_b;
      4'd7:    alu_out = ($signed(alu_a) < $signed(alu_b)) ? 32'd1 : 32'd0;
      4'd12:   alu_out = ~(alu_a | alu_b);
      default: alu_out = '0;
    endcase
    alu_zero = (alu_out == '0);
  end

  function automatic void ref_op(input logic [3:0] ctl, input logic [W-1:0] a, input logic [W-1:0] b,
                                 output logic [W-1:0] d, output bit z, output bit e);
    bit legal;
    legal = ctl inside {4'd0, 4'd1, 4'd2, 4'd6, 4'd7, 4'd12};
    d = '0;
    case (ctl)
      4'd0:    d = a & b;
      4'd1:    d = a | b;
      4'd2:    d = a + b;
      4'd6:    d = a - b;
      4'd7:    d = (int'(a) < int'(b)) ? 32'd1 : 32'd0;
      4'd12:   d = ~(a | b);
      default: d = '0;
    endcase
    if (!legal) begin
      z = !OPCHK;
      e = OPCHK;
    end else begin
      z = (d == '0);
      e = 1'b0;
    end
  endfunction

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chki(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tmo(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s: timed out, got no event expected one within 20 cycles", name);
  endtask

  task automatic do_reset;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic wait_ready(input bit id, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      chk1("one_ready", req0_ready & req1_ready, 1'b0);
      ok = id ? req1_ready : req0_ready;
    end
    if (!ok) tmo("wait_ready");
  endtask

  task automatic wait_rsp(output int lat);
    bit ok;
    ok = 1'b0;
    lat = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (rsp_valid) begin
        ok = 1'b1;
        lat = i + 1;
      end
    end
    if (!ok) tmo("wait_rsp");
  endtask

  task automatic run_op(input bit id, input logic [3:0] ctl, input logic [W-1:0] a, input logic [W-1:0] b,
                        output int lat);
    bit ok;
    @(posedge clk);
    #1;
    if (id) begin
      req1_valid = 1'b1; req1_ctl = ctl; req1_a = a; req1_b = b;
    end else begin
      req0_valid = 1'b1; req0_ctl = ctl; req0_a = a; req0_b = b;
    end
    wait_ready(id, ok);
    @(posedge clk);
    #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    wait_rsp(lat);
  endtask

  task automatic rand_op(output logic [3:0] c, output logic [W-1:0] a, output logic [W-1:0] b);
    logic [3:0] ops[8];
    ops = '{4'd0, 4'd1, 4'd2, 4'd6, 4'd7, 4'd12, 4'd5, 4'd15};
    c = ops[$urandom_range(0, 7)];
    a = $urandom;
    b = ($urandom_range(0, 3) == 0) ? a : $urandom;
  endtask

  // One observation per cycle, taken mid-cycle; reports which requester is handshaking.
  task automatic mon_step(output bit g0, output bit g1);
    exp_t         e;
    logic [W-1:0] d;
    bit           z, er, gid;
    g0 = req0_valid & req0_ready;
    g1 = req1_valid & req1_ready;
    chk1("mon_one_ready", req0_ready & req1_ready, 1'b0);
    if (q.size() != 0) begin
      chk1("mon_ready_busy", req0_ready | req1_ready, 1'b0);
    end else if (req0_valid || req1_valid) begin
      gid = (req0_valid && req1_valid) ? !m_last : req1_valid;
      chki("mon_grant", int'({req1_ready, req0_ready}), gid ? 2 : 1);
      if (g0 || g1) begin
        if (g1) ref_op(req1_ctl, req1_a, req1_b, d, z, er);
        else    ref_op(req0_ctl, req0_a, req0_b, d, z, er);
        e.id = g1; e.d = d; e.z = z; e.e = er; e.cyc = cyc; e.lat = er ? 1 : 2;
        q.push_back(e);
        m_last = g1;
      end
    end
    if (rsp_valid) begin
      if (q.size() == 0) begin
        tmo("mon_spurious_rsp");
      end else begin
        if (!prev_valid) chki("mon_latency", cyc - q[0].cyc, q[0].lat);
        chk1("mon_id", rsp_id, q[0].id);
        chk("mon_data", rsp_data, q[0].d);
        chk1("mon_zero", rsp_zero, q[0].z);
        chk1("mon_err", rsp_err, q[0].e);
        if (rsp_ready) void'(q.pop_front());
      end
    end
    prev_valid = rsp_valid;
  endtask

  initial begin
    bit ok, g0, g1;
    int lat, c1, c2;
    rst_n = 1'b0; rsp_ready = 1'b0;
    req0_valid = 1'b0; req0_ctl = '0; req0_a = '0; req0_b = '0;
    req1_valid = 1'b0; req1_ctl = '0; req1_a = '0; req1_b = '0;

    tbl[0] = '{1'b0, 4'd2,  32'd5,          32'd7,          32'd12,         1'b0, 1'b0};
    tbl[1] = '{1'b0, 4'd6,  32'd9,          32'd9,          32'd0,          1'b1, 1'b0};
    tbl[2] = '{1'b1, 4'd7,  32'd3,          32'd4,          32'd1,          1'b0, 1'b0};
    tbl[3] = '{1'b1, 4'd0,  32'hFFFF0000,   32'h0F0F0F0F,   32'h0F0F0000,   1'b0, 1'b0};
    tbl[4] = '{1'b1, 4'd1,  32'hFFFF0000,   32'h0F0F0F0F,   32'hFFFF0F0F,   1'b0, 1'b0};
    tbl[5] = '{1'b0, 4'd12, 32'd0,          32'd0,          32'hFFFFFFFF,   1'b0, 1'b0};
    tbl[6] = '{1'b0, 4'd2,  32'hFFFFFFFF,   32'd1,          32'd0,          1'b1, 1'b0};
    tbl[7] = '{1'b1, 4'd6,  32'd0,          32'd1,          32'hFFFFFFFF,   1'b0, 1'b0};
    tbl[8] = '{1'b1, 4'd7,  32'hFFFFFFFF,   32'd0,          32'd1,          1'b0, 1'b0};
    tbl[9] = '{1'b1, 4'd5,  32'd1,          32'd1,          32'd0,          !OPCHK, OPCHK};

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chki("rst_alu_ctl", int'(alu_ctl), 0);
    chk("rst_alu_a", alu_a, 32'd0);
    chk("rst_alu_b", alu_b, 32'd0);
    chk1("rst_rsp_valid", rsp_valid, 1'b0);
    chk1("rst_rsp_id", rsp_id, 1'b0);
    chk("rst_rsp_data", rsp_data, 32'd0);
    chk1("rst_rsp_zero", rsp_zero, 1'b0);
    chk1("rst_rsp_err", rsp_err, 1'b0);
    chk1("rst_busy", busy, 1'b0);

    // First op straight after reset release: ADD 5+7
    @(posedge clk);
    #1;
    rst_n = 1'b1; rsp_ready = 1'b1;
    req0_valid = 1'b1; req0_ctl = 4'd2; req0_a = 32'd5; req0_b = 32'd7;
    @(negedge clk);
    chk1("t1_ready0", req0_ready, 1'b1);
    chk1("t1_ready1", req1_ready, 1'b0);
    chk1("t1_busy_idle", busy, 1'b0);
    @(posedge clk);
    #1 req0_valid = 1'b0;
    @(negedge clk);
    chki("t1_alu_ctl", int'(alu_ctl), 2);
    chk("t1_alu_a", alu_a, 32'd5);
    chk("t1_alu_b", alu_b, 32'd7);
    chk1("t1_busy_exec", busy, 1'b1);
    chk1("t1_no_rsp_yet", rsp_valid, 1'b0);
    @(negedge clk);
    chk1("t1_rsp_valid", rsp_valid, 1'b1);
    chk1("t1_rsp_id", rsp_id, 1'b0);
    chk("t1_rsp_data", rsp_data, 32'd12);
    chk1("t1_rsp_zero", rsp_zero, 1'b0);
    chk1("t1_busy_resp", busy, 1'b1);
    @(negedge clk);
    chk1("t1_rsp_done", rsp_valid, 1'b0);
    chk1("t1_busy_done", busy, 1'b0);

    // Vector table
    for (int i = 0; i < 10; i++) begin
      run_op(tbl[i].id, tbl[i].ctl, tbl[i].a, tbl[i].b, lat);
      chki($sformatf("tbl%0d_lat", i), lat, tbl[i].e ? 1 : 2);
      chk1($sformatf("tbl%0d_id", i), rsp_id, tbl[i].id);
      chk($sformatf("tbl%0d_data", i), rsp_data, tbl[i].d);
      chk1($sformatf("tbl%0d_zero", i), rsp_zero, tbl[i].z);
      chk1($sformatf("tbl%0d_err", i), rsp_err, tbl[i].e);
    end

    // Continuous contention alternates grants, starting with requester 0
    do_reset();
    rsp_ready = 1'b1;
    req0_valid = 1'b1; req0_ctl = 4'd6; req0_a = 32'd9; req0_b = 32'd9;
    req1_valid = 1'b1; req1_ctl = 4'd7; req1_a = 32'd3; req1_b = 32'd4;
    for (int g = 0; g < 4; g++) begin
      ok = 1'b0;
      for (int i = 0; i < 20 && !ok; i++) begin
        @(negedge clk);
        chk1("alt_one_ready", req0_ready & req1_ready, 1'b0);
        if (req0_ready || req1_ready) begin
          ok = 1'b1;
          chk1($sformatf("alt_grant%0d", g), req1_ready, 1'((g % 2)));
        end
      end
      if (!ok) tmo("alt_ready");
      wait_rsp(lat);
      chki("alt_lat", lat, 2);
      chk1("alt_id", rsp_id, 1'((g % 2)));
      chk("alt_data", rsp_data, (g % 2) ? 32'd1 : 32'd0);
      chk1("alt_zero", rsp_zero, (g % 2) ? 1'b0 : 1'b1);
    end
    @(posedge clk);
    #1;
    req0_valid = 1'b0; req1_valid = 1'b0;

    // Response backpressure holds everything; req1 waits until the slot frees
    rsp_ready = 1'b0;
    req0_valid = 1'b1; req0_ctl = 4'd2; req0_a = 32'd10; req0_b = 32'd20;
    wait_ready(1'b0, ok);
    @(posedge clk);
    #1;
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_ctl = 4'd1; req1_a = 32'd3; req1_b = 32'd4;
    wait_rsp(lat);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      chk1("bp_valid", rsp_valid, 1'b1);
      chk1("bp_id", rsp_id, 1'b0);
      chk("bp_data", rsp_data, 32'd30);
      chk1("bp_zero", rsp_zero, 1'b0);
      chk1("bp_ready1", req1_ready, 1'b0);
    end
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    @(negedge clk);
    chk1("bp_hs_valid", rsp_valid, 1'b1);
    chk1("bp_hs_ready1", req1_ready, 1'b0);
    @(negedge clk);
    chk1("bp_next_grant1", req1_ready, 1'b1);
    chk1("bp_next_valid", rsp_valid, 1'b0);
    @(posedge clk);
    #1 req1_valid = 1'b0;
    wait_rsp(lat);
    chk1("bp_r1_id", rsp_id, 1'b1);
    chk("bp_r1_data", rsp_data, 32'd7);

    // Illegal opcode after a legal op
    run_op(1'b0, 4'd2, 32'd5, 32'd7, lat);
    chk("ill_pre_data", rsp_data, 32'd12);
    run_op(1'b0, 4'd5, 32'd1, 32'd1, lat);
    chki("ill_lat", lat, OPCHK ? 1 : 2);
    chki("ill_alu_ctl", int'(alu_ctl), OPCHK ? 2 : 5);
    chk("ill_alu_a", alu_a, OPCHK ? 32'd5 : 32'd1);
    chk("ill_data", rsp_data, 32'd0);
    chk1("ill_zero", rsp_zero, !OPCHK);
    chk1("ill_err", rsp_err, OPCHK);

    // Back-to-back single requester, AND then OR on the same operands
    @(posedge clk);
    #1;
    req1_valid = 1'b1; req1_ctl = 4'd0; req1_a = 32'hFFFF0000; req1_b = 32'h0F0F0F0F;
    wait_ready(1'b1, ok);
    c1 = cyc;
    @(posedge clk);
    #1 req1_ctl = 4'd1;
    wait_rsp(lat);
    chk("b2b_and", rsp_data, 32'h0F0F0000);
    wait_ready(1'b1, ok);
    c2 = cyc;
    chki("b2b_gap", c2 - c1, 3);
    @(posedge clk);
    #1 req1_valid = 1'b0;
    wait_rsp(lat);
    chk("b2b_or", rsp_data, 32'hFFFF0F0F);

    // Reset during EXEC abandons the op
    @(posedge clk);
    #1;
    req1_valid = 1'b1; req1_ctl = 4'd12; req1_a = 32'd0; req1_b = 32'd0;
    wait_ready(1'b1, ok);
    @(posedge clk);
    #1;
    req1_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    chk1("rx_in_exec", busy, 1'b1);
    chk1("rx_exec_novalid", rsp_valid, 1'b0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chki("rx_alu_ctl", int'(alu_ctl), 0);
    chk("rx_alu_a", alu_a, 32'd0);
    chk("rx_alu_b", alu_b, 32'd0);
    chk("rx_rsp_data", rsp_data, 32'd0);
    chk1("rx_rsp_id", rsp_id, 1'b0);
    chk1("rx_rsp_zero", rsp_zero, 1'b0);
    chk1("rx_rsp_err", rsp_err, 1'b0);
    chk1("rx_busy", busy, 1'b0);
    for (int i = 0; i < 3; i++) begin
      chk1("rx_no_rsp", rsp_valid, 1'b0);
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    req0_valid = 1'b1; req0_ctl = 4'd2; req0_a = 32'd1; req0_b = 32'd1;
    req1_valid = 1'b1; req1_ctl = 4'd2; req1_a = 32'd2; req1_b = 32'd2;
    @(negedge clk);
    chk1("rx_tie_r0", req0_ready, 1'b1);
    chk1("rx_tie_r1", req1_ready, 1'b0);
    @(posedge clk);
    #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    wait_rsp(lat);
    chk1("rx_tie_id", rsp_id, 1'b0);
    chk("rx_tie_data", rsp_data, 32'd2);

    // Randomized traffic against the transaction model
    do_reset();
    q.delete();
    m_last = 1'b1;
    prev_valid = 1'b0;
    g0 = 1'b0;
    g1 = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      @(posedge clk);
      #1;
      if (g0) req0_valid = 1'b0;
      if (g1) req1_valid = 1'b0;
      if (!req0_valid && $urandom_range(0, 2) == 0) begin
        req0_valid = 1'b1;
        rand_op(req0_ctl, req0_a, req0_b);
      end
      if (!req1_valid && $urandom_range(0, 2) == 0) begin
        req1_valid = 1'b1;
        rand_op(req1_ctl, req1_a, req1_b);
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      mon_step(g0, g1);
    end
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
      @(negedge clk);
      mon_step(g0, g1);
    end
    chki("drain_empty", q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
